cm3_matrix_ahb_initiator: RTL and testbench

- Single-channel AHB initiator that turns a simple command/response interface into AHB single transfers.
- Address and data phases are pipelined, so back-to-back commands reach one transfer per cycle with zero-wait slaves.
- Drives a bus-matrix slave port; the complement of the matrix default slave.
- Handles the two-cycle ERROR response, including cancelling the pipelined next transfer.

---
 rtl/cm3_matrix_ahb_initiator.sv | 95 +++++++++
 tb/tb_cm3_matrix_ahb_initiator.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cm3_matrix_ahb_initiator.sv
// Single-channel AHB initiator: command/response in, pipelined AHB single transfers out.
// Slot A is the address phase, slot D the data phase; ERROR cancels whatever sits in A.
module cm3_matrix_ahb_initiator #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_error,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        HTRANS,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  input  logic [DATA_W-1:0] HRDATA
);
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic              a_vld, d_vld, d_write, cancel_pend;
  logic              resp_err, err1, accept;
  logic [DATA_W-1:0] a_wdata;

  // HTRANS is the slot-A valid flop itself, so the bus output stays registered.
  assign a_vld     = HTRANS[1];
  assign resp_err  = HRESP != 2'b00;
  assign err1      = d_vld & ~HREADY & resp_err;
  assign cmd_ready = HRESETn & ~cancel_pend & ~err1 & (~a_vld | HREADY);
  assign accept    = cmd_valid & cmd_ready;

  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      HTRANS      <= IDLE;
      HADDR       <= '0;
      HWRITE      <= 1'b0;
      HSIZE       <= 3'b000;
      a_wdata     <= '0;
      d_vld       <= 1'b0;
      d_write     <= 1'b0;
      HWDATA      <= '0;
      cancel_pend <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_error   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
      if (HREADY) begin
        if (d_vld) begin
          rsp_valid <= 1'b1;
          rsp_error <= resp_err;
          if (!d_write && !resp_err) rsp_rdata <= HRDATA;
        end
        d_vld   <= a_vld;
        d_write <= HWRITE;
        if (a_vld) HWDATA <= a_wdata;
      end
      // The cancelled transfer reports one cycle after the erroring one has drained from D.
      if (cancel_pend && !d_vld) begin
        rsp_valid   <= 1'b1;
        rsp_error   <= 1'b1;
        cancel_pend <= 1'b0;
      end
      if (err1 && a_vld) cancel_pend <= 1'b1;
      if (accept) begin
        HTRANS  <= NONSEQ;
        HADDR   <= cmd_addr;
        HWRITE  <= cmd_write;
        HSIZE   <= cmd_size;
        a_wdata <= cmd_wdata;
      end else if (HREADY || err1) begin
        HTRANS  <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_cm3_matrix_ahb_initiator.sv
// Bench for cm3_matrix_ahb_initiator: directed scenarios plus randomized traffic against
// an AHB slave model and an in-order command/response scoreboard.
module tb_cm3_matrix_ahb_initiator;
  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [1:0]  HTRANS, HRESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE, HMASTLOCK, HREADY;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  always #5 HCLK = ~HCLK;

  cm3_matrix_ahb_initiator #(.ADDR_W(32), .DATA_W(32), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
    .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model: every accepted command, in order.
  logic [31:0] m_addr [1024];
  logic        m_write[1024];
  logic [2:0]  m_size [1024];
  logic [31:0] m_wdata[1024];
  bit          m_cancel[1024];
  int          cap_cyc[1024];
  int          next_id = 0;
  int          rsp_idx = 0;
  int          rsp_seen = 0;
  int          pend_q[$];
  int          wmax = 0;
  int          wait_next = -1;

  // Slave data: reads return a fixed function of the address; 0xF... is unmapped.
  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'hFEADBEFF;
  endfunction
  function automatic bit unmapped(input logic [31:0] a);
    return a[31:28] == 4'hF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Slave model + scoreboard. Samples at negedge, acts just after the following posedge.
  logic        s_rst, s_rdy, s_cv, s_cr, s_cw, s_wr;
  logic [1:0]  s_tr;
  logic [2:0]  s_sz, s_cs;
  logic [31:0] s_ad, s_wd, s_ca, s_cwd;
  bit          dp_act, dp_err, dp_wr;
  int          dp_id, wl, est;
  logic [31:0] dp_addr;

  initial begin
    dp_act = 0; dp_err = 0; dp_wr = 0; dp_id = 0; wl = 0; est = 0; dp_addr = '0;
    HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0;
    forever begin
      @(negedge HCLK);
      s_rst = HRESETn; s_rdy = HREADY; s_tr = HTRANS; s_ad = HADDR; s_wr = HWRITE;
      s_sz = HSIZE; s_wd = HWDATA; s_cv = cmd_valid; s_cr = cmd_ready; s_cw = cmd_write;
      s_ca = cmd_addr; s_cs = cmd_size; s_cwd = cmd_wdata;
      if (rsp_valid === 1'b1) begin
        if (rsp_idx >= next_id) chk("rsp_unexpected", {63'b0, rsp_valid}, 64'd0);
        else begin
          automatic int  id = rsp_idx;
          automatic bit  e  = unmapped(m_addr[id]) || m_cancel[id];
          chk("rsp_error", {63'b0, rsp_error}, {63'b0, e});
          if (!e) chk("rsp_rdata", {32'b0, rsp_rdata}, m_write[id] ? 64'd0 : {32'b0, rd_of(m_addr[id])});
          else if (m_cancel[id]) chk("rsp_cancel_rdata", {32'b0, rsp_rdata}, 64'd0);
          rsp_idx++;
          rsp_seen++;
        end
      end
      @(posedge HCLK);
      #1;
      if (!s_rst) begin
        pend_q.delete();
        dp_act = 0;
        rsp_idx = next_id;
      end else begin
        if (s_rdy) begin
          // An ERROR completing cancels the command the initiator had already accepted behind it.
          if (dp_act && dp_err) begin
            if (pend_q.size() > 0) m_cancel[pend_q.pop_front()] = 1;
          end else if (dp_act && dp_wr) begin
            chk("hwdata", {32'b0, s_wd}, {32'b0, m_wdata[dp_id]});
          end
          dp_act = (s_tr == 2'b10);
          if (dp_act) begin
            if (pend_q.size() == 0) begin
              chk("bus_unexpected", {62'b0, s_tr}, 64'd0);
              dp_act = 0;
            end else begin
              dp_id = pend_q.pop_front();
              chk("haddr", {32'b0, s_ad}, {32'b0, m_addr[dp_id]});
              chk("hwrite", {63'b0, s_wr}, {63'b0, m_write[dp_id]});
              chk("hsize", {61'b0, s_sz}, {61'b0, m_size[dp_id]});
              cap_cyc[dp_id] = cyc;
              dp_wr = s_wr;
              dp_addr = s_ad;
              dp_err = unmapped(s_ad);
              wl = (wait_next >= 0) ? wait_next : $urandom_range(wmax, 0);
              wait_next = -1;
              est = 0;
            end
          end
        end
        if (s_cv && s_cr) begin
          m_addr[next_id] = s_ca; m_write[next_id] = s_cw; m_size[next_id] = s_cs;
          m_wdata[next_id] = s_cwd; m_cancel[next_id] = 0;
          pend_q.push_back(next_id);
          next_id++;
        end
      end
      HRDATA = $urandom;
      if (!dp_act) begin
        HREADY = 1'b1; HRESP = 2'b00;
      end else if (wl > 0) begin
        HREADY = 1'b0; HRESP = 2'b00; wl--;
      end else if (dp_err && est == 0) begin
        HREADY = 1'b0; HRESP = 2'b01; est = 1;
      end else if (dp_err) begin
        HREADY = 1'b1; HRESP = 2'b01;
      end else begin
        HREADY = 1'b1; HRESP = 2'b00;
        if (!dp_wr) HRDATA = rd_of(dp_addr);
      end
    end
  end

  // Presents a command and returns 2ns after the edge that accepted it, cmd_valid still high.
  task automatic send(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd);
    int t;
    bit done;
    t = 0; done = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_size = sz; cmd_wdata = wd;
    while (!done) begin
      @(negedge HCLK);
      done = cmd_ready;
      @(posedge HCLK);
      #2;
      t++;
      if (!done && t > 60) begin
        chk("accept_timeout", t, 64'd0);
        done = 1;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (rsp_idx < next_id && t < 300) begin
      @(negedge HCLK);
      t++;
    end
    chk("drain", rsp_idx, next_id);
    repeat (3) @(negedge HCLK);
  endtask

  initial begin
    int base, r0;
    logic [31:0] wd1, wd2;
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_htrans", {62'b0, HTRANS}, 64'd0);
    chk("rst_haddr", {32'b0, HADDR}, 64'd0);
    chk("rst_hwrite", {63'b0, HWRITE}, 64'd0);
    chk("rst_hsize", {61'b0, HSIZE}, 64'd0);
    chk("rst_hwdata", {32'b0, HWDATA}, 64'd0);
    chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("rst_rsp_error", {63'b0, rsp_error}, 64'd0);
    chk("rst_rsp_rdata", {32'b0, rsp_rdata}, 64'd0);
    chk("rst_cmd_ready", {63'b0, cmd_ready}, 64'd0);
    chk("hburst", {61'b0, HBURST}, 64'd0);
    chk("hprot", {60'b0, HPROT}, 64'h3);
    chk("hmastlock", {63'b0, HMASTLOCK}, 64'd0);
    @(posedge HCLK); #2;
    HRESETn = 1'b1;

    // Idle
    repeat (10) begin
      @(negedge HCLK);
      chk("idle_htrans", {62'b0, HTRANS}, 64'd0);
      chk("idle_rsp_valid", {63'b0, rsp_valid}, 64'd0);
      chk("idle_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    end

    // Single read, zero wait: NONSEQ one cycle, response two cycles later
    @(posedge HCLK); #2;
    send(32'h2000_0010, 1'b0, 3'd2, 32'h0);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    chk("sr_htrans", {62'b0, HTRANS}, 64'h2);
    chk("sr_haddr", {32'b0, HADDR}, 64'h2000_0010);
    @(negedge HCLK);
    chk("sr_htrans_once", {62'b0, HTRANS}, 64'd0);
    chk("sr_rsp_early", {63'b0, rsp_valid}, 64'd0);
    @(negedge HCLK);
    chk("sr_rsp_valid", {63'b0, rsp_valid}, 64'd1);
    chk("sr_rsp_rdata", {32'b0, rsp_rdata}, 64'hDEADBEEF);
    chk("sr_rsp_error", {63'b0, rsp_error}, 64'd0);
    drain();

    // Back-to-back writes
    @(posedge HCLK); #2;
    base = next_id; r0 = rsp_seen;
    for (int i = 0; i < 4; i++) send(32'(i * 4), 1'b1, 3'd2, $urandom);
    cmd_valid = 1'b0;
    drain();
    for (int i = 1; i < 4; i++) chk("b2b_consecutive", cap_cyc[base+i] - cap_cyc[base+i-1], 64'd1);
    chk("b2b_rsp_count", rsp_seen - r0, 64'd4);

    // Wait states on transfer 1 of 2
    @(posedge HCLK); #2;
    wd1 = $urandom; wd2 = $urandom;
    wait_next = 3;
    send(32'h2000_0040, 1'b1, 3'd2, wd1);
    send(32'h2000_0044, 1'b1, 3'd2, wd2);
    cmd_valid = 1'b0;
    repeat (3) begin
      @(negedge HCLK);
      chk("ws_cmd_ready", {63'b0, cmd_ready}, 64'd0);
      chk("ws_htrans", {62'b0, HTRANS}, 64'h2);
      chk("ws_haddr", {32'b0, HADDR}, {32'b0, 32'h2000_0044});
      chk("ws_hwdata", {32'b0, HWDATA}, {32'b0, wd1});
    end
    drain();

    // ERROR with a pipelined next transfer
    @(posedge HCLK); #2;
    wait_next = 0;
    send(32'hF000_0000, 1'b0, 3'd2, 32'h0);
    send(32'h2000_0100, 1'b0, 3'd2, 32'h0);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    chk("e1_cmd_ready", {63'b0, cmd_ready}, 64'd0);
    chk("e1_htrans", {62'b0, HTRANS}, 64'h2);
    @(negedge HCLK);
    chk("e2_htrans", {62'b0, HTRANS}, 64'd0);
    chk("e2_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    @(negedge HCLK);
    chk("err_rsp_valid", {63'b0, rsp_valid}, 64'd1);
    chk("err_rsp_error", {63'b0, rsp_error}, 64'd1);
    @(negedge HCLK);
    chk("cancel_rsp_valid", {63'b0, rsp_valid}, 64'd1);
    chk("cancel_rsp_error", {63'b0, rsp_error}, 64'd1);
    chk("cancel_rsp_rdata", {32'b0, rsp_rdata}, 64'd0);
    @(negedge HCLK);
    chk("post_err_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("post_err_cmd_ready", {63'b0, cmd_ready}, 64'd1);
    @(posedge HCLK); #2;
    send(32'h2000_0200, 1'b0, 3'd2, 32'h0);
    cmd_valid = 1'b0;
    drain();

    // Reset during a waited write
    @(posedge HCLK); #2;
    wait_next = 6;
    send(32'h2000_0080, 1'b1, 3'd2, $urandom);
    cmd_valid = 1'b0;
    repeat (2) @(posedge HCLK);
    #2;
    HRESETn = 1'b0;
    @(posedge HCLK); #2;
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("mrst_htrans", {62'b0, HTRANS}, 64'd0);
    chk("mrst_hwdata", {32'b0, HWDATA}, 64'd0);
    repeat (8) begin
      @(negedge HCLK);
      chk("mrst_no_rsp", {63'b0, rsp_valid}, 64'd0);
    end
    @(posedge HCLK); #2;
    send(32'h2000_0020, 1'b0, 3'd1, 32'h0);
    cmd_valid = 1'b0;
    drain();

    // Randomized traffic with wait states and occasional unmapped addresses
    wmax = 3;
    @(posedge HCLK); #2;
    repeat (300) begin
      if ($urandom_range(3, 0) == 0) begin
        cmd_valid = 1'b0;
        @(posedge HCLK); #2;
      end else begin
        send(($urandom_range(7, 0) == 0) ? {4'hF, 28'($urandom)} : {4'h2, 28'($urandom)},
             1'($urandom), 3'($urandom_range(2, 0)), $urandom);
      end
    end
    cmd_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
